// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage.
// Holds the 4-bit ALU control codes, ALUOp encodings, R-type funct values
// and forwarding select codes. Files that use them import alu_pkg::*.
package alu_pkg;

    // Codes driven onto ALUControl
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1010;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SRL = 4'b1101;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    // ALUOp encodings from the main decoder
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_RTYP = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_SLT  = 3'b110,
        OP_ADD2 = 3'b111
    } aluop_e;

    // R-type funct field values
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;

    // Forwarding selects; 2'b11 behaves like FWD_REG
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bus bundle between the decode/hazard logic and the ALU issue stage.
// master: drives decode-side fields, forwarding selects/sources, stall/flush.
// slave : the issue stage; drives the execute-side ALU operands and control.
interface alu_issue_stage_if #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
);
    logic             StallE;
    logic             FlushE;
    logic             ValidD;
    logic [2:0]       ALUOpD;
    logic [5:0]       FunctD;
    logic [4:0]       ShamtD;
    logic             ALUSrcD;
    logic             RegDstD;
    logic [WIDTH-1:0] RD1D;
    logic [WIDTH-1:0] RD2D;
    logic [WIDTH-1:0] SignImmD;
    logic [REGW-1:0]  RtD;
    logic [REGW-1:0]  RdD;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic [WIDTH-1:0] ResultW;
    logic [WIDTH-1:0] ALUOutM;
    logic [3:0]       ALUControlE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic [WIDTH-1:0] WriteDataE;
    logic [REGW-1:0]  WriteRegE;
    logic             ValidE;
    logic             IllegalE;

    modport master (
        output StallE, FlushE, ValidD, ALUOpD, FunctD, ShamtD, ALUSrcD, RegDstD,
               RD1D, RD2D, SignImmD, RtD, RdD, ForwardAE, ForwardBE, ResultW, ALUOutM,
        input  ALUControlE, SrcAE, SrcBE, WriteDataE, WriteRegE, ValidE, IllegalE
    );

    modport slave (
        input  StallE, FlushE, ValidD, ALUOpD, FunctD, ShamtD, ALUSrcD, RegDstD,
               RD1D, RD2D, SignImmD, RtD, RdD, ForwardAE, ForwardBE, ResultW, ALUOutM,
        output ALUControlE, SrcAE, SrcBE, WriteDataE, WriteRegE, ValidE, IllegalE
    );
endinterface

// File: rtl/alu_control_decoder.sv
// Combinational ALU control decoder.
// Ports: alu_op (3) and funct (6) in; alu_control (4), shift_imm and
// illegal out. shift_imm marks shifts whose amount comes from the shamt
// field rather than from rs. Unknown R-type functs fall back to add.
module alu_control_decoder
    import alu_pkg::*;
(
    input  logic [2:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       shift_imm,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        shift_imm   = 1'b0;
        illegal     = 1'b0;
        unique case (aluop_e'(alu_op))
            OP_ADD, OP_ADD2: alu_control = ALU_ADD;
            OP_SUB:          alu_control = ALU_SUB;
            OP_AND:          alu_control = ALU_AND;
            OP_OR:           alu_control = ALU_OR;
            OP_XOR:          alu_control = ALU_XOR;
            OP_SLT:          alu_control = ALU_SLT;
            OP_RTYP: begin
                case (funct)
                    F_ADD, F_ADDU: alu_control = ALU_ADD;
                    F_SUB, F_SUBU: alu_control = ALU_SUB;
                    F_AND:         alu_control = ALU_AND;
                    F_OR:          alu_control = ALU_OR;
                    F_XOR:         alu_control = ALU_XOR;
                    F_NOR:         alu_control = ALU_NOR;
                    F_SLT:         alu_control = ALU_SLT;
                    F_SLL: begin
                        alu_control = ALU_SLL;
                        shift_imm   = 1'b1;
                    end
                    F_SLLV:        alu_control = ALU_SLL;
                    F_SRL: begin
                        alu_control = ALU_SRL;
                        shift_imm   = 1'b1;
                    end
                    F_SRLV:        alu_control = ALU_SRL;
                    F_SRA: begin
                        alu_control = ALU_SRA;
                        shift_imm   = 1'b1;
                    end
                    F_SRAV:        alu_control = ALU_SRA;
                    default: begin
                        alu_control = ALU_ADD;
                        illegal     = 1'b1;
                    end
                endcase
            end
            default:         alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes ALU control in D, registers the decode bundle
// into E (reset > flush > stall > load), then forwards and steers operands
// so the ALU sees final SrcA/SrcB in E.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries the
// D-side fields, stall/flush, forwarding selects/sources and the E outputs.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    alu_issue_stage_if.slave bus
);

    logic [3:0]       alu_control_d;
    logic             shift_imm_d;
    logic             illegal_d;
    logic [REGW-1:0]  write_reg_d;

    logic [3:0]       alu_control_e;
    logic             shift_imm_e;
    logic             alu_src_e;
    logic [WIDTH-1:0] rd1_e;
    logic [WIDTH-1:0] rd2_e;
    logic [WIDTH-1:0] sign_imm_e;
    logic [4:0]       shamt_e;
    logic [REGW-1:0]  write_reg_e;
    logic             valid_e;
    logic             illegal_e;

    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;

    alu_control_decoder u_dec (
        .alu_op      (bus.ALUOpD),
        .funct       (bus.FunctD),
        .alu_control (alu_control_d),
        .shift_imm   (shift_imm_d),
        .illegal     (illegal_d)
    );

    assign write_reg_d = bus.RegDstD ? bus.RdD : bus.RtD;

    always_ff @(posedge clk) begin
        if (reset || bus.FlushE) begin
            alu_control_e <= '0;
            shift_imm_e   <= 1'b0;
            alu_src_e     <= 1'b0;
            rd1_e         <= '0;
            rd2_e         <= '0;
            sign_imm_e    <= '0;
            shamt_e       <= '0;
            write_reg_e   <= '0;
            valid_e       <= 1'b0;
            illegal_e     <= 1'b0;
        end else if (!bus.StallE) begin
            alu_control_e <= alu_control_d;
            shift_imm_e   <= shift_imm_d;
            alu_src_e     <= bus.ALUSrcD;
            rd1_e         <= bus.RD1D;
            rd2_e         <= bus.RD2D;
            sign_imm_e    <= bus.SignImmD;
            shamt_e       <= bus.ShamtD;
            write_reg_e   <= write_reg_d;
            valid_e       <= bus.ValidD;
            illegal_e     <= illegal_d;
        end
    end

    // Forwarding muxes stay live while E is stalled so a held instruction
    // still picks up results arriving in M/W.
    always_comb begin
        fwd_a = rd1_e;
        case (bus.ForwardAE)
            FWD_W:   fwd_a = bus.ResultW;
            FWD_M:   fwd_a = bus.ALUOutM;
            default: fwd_a = rd1_e;
        endcase
    end

    always_comb begin
        fwd_b = rd2_e;
        case (bus.ForwardBE)
            FWD_W:   fwd_b = bus.ResultW;
            FWD_M:   fwd_b = bus.ALUOutM;
            default: fwd_b = rd2_e;
        endcase
    end

    assign bus.SrcAE       = shift_imm_e ? {{(WIDTH-5){1'b0}}, shamt_e} : fwd_a;
    assign bus.SrcBE       = alu_src_e ? sign_imm_e : fwd_b;
    assign bus.WriteDataE  = fwd_b;
    assign bus.ALUControlE = alu_control_e;
    assign bus.WriteRegE   = write_reg_e;
    assign bus.ValidE      = valid_e;
    assign bus.IllegalE    = illegal_e;

endmodule
